// File: rtl/min_scan_controller.sv
// Push-button operand loader with a sequential unsigned minimum scan over four operands.
// Each button is synchronized and edge-detected; a load or start kicks off a 6-cycle scan.
module min_scan_controller #(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     pb,
    input  logic [W-1:0]   holder,
    input  logic           start,
    output logic [4*W-1:0] num_flat,
    output logic [1:0]     min_index,
    output logic [W-1:0]   min_value,
    output logic           result_valid,
    output logic           done,
    output logic           busy,
    output logic [7:0]     char_min
);

    typedef enum logic [1:0] {IDLE, INIT, SCAN, DONE} state_t;

    state_t                      state_q, state_d;
    logic [3:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]                  prev_q, prev_d;
    logic [3:0]                  synced;
    logic [3:0]                  ld;
    logic                        ld_any;
    logic [3:0][W-1:0]           num_q, num_d;
    logic [1:0]                  cand_idx_q, cand_idx_d;
    logic [W-1:0]                cand_val_q, cand_val_d;
    logic [1:0]                  ptr_q, ptr_d;
    logic [1:0]                  min_index_q, min_index_d;
    logic [W-1:0]                min_value_q, min_value_d;
    logic                        valid_q, valid_d;

    // Synchronizer shifts toward the MSB; the MSB is the clean button level.
    always_comb begin
        sync_d = sync_q;
        synced = '0;
        for (int k = 0; k < 4; k++) begin
            sync_d[k] = {sync_q[k][SYNC_STAGES-2:0], pb[k]};
            synced[k] = sync_q[k][SYNC_STAGES-1];
        end
        prev_d = synced;
        ld     = synced & ~prev_q;
        ld_any = |ld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Any load restarts the scan, even from DONE, so results never describe stale operands.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ld_any || start) state_d = INIT;
            INIT: state_d = ld_any ? INIT : SCAN;
            SCAN: begin
                if (ld_any)              state_d = INIT;
                else if (ptr_q == 2'd3)  state_d = DONE;
                else                     state_d = SCAN;
            end
            DONE: state_d = ld_any ? INIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == INIT) || (state_q == SCAN);
        done = (state_q == DONE);
    end

    always_comb begin
        num_d       = num_q;
        cand_idx_d  = cand_idx_q;
        cand_val_d  = cand_val_q;
        ptr_d       = ptr_q;
        min_index_d = min_index_q;
        min_value_d = min_value_q;
        valid_d     = valid_q;
        for (int k = 0; k < 4; k++) begin
            if (ld[k]) num_d[k] = holder;
        end
        case (state_q)
            INIT: begin
                cand_idx_d = 2'd0;
                cand_val_d = num_q[0];
                ptr_d      = 2'd1;
            end
            SCAN: begin
                // Strict less-than keeps the lowest index on ties.
                if (num_q[ptr_q] < cand_val_q) begin
                    cand_idx_d = ptr_q;
                    cand_val_d = num_q[ptr_q];
                end
                ptr_d = ptr_q + 2'd1;
            end
            DONE: begin
                min_index_d = cand_idx_q;
                min_value_d = cand_val_q;
            end
            default: ;
        endcase
        if (ld_any)                valid_d = 1'b0;
        else if (state_q == DONE)  valid_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            prev_q      <= '0;
            num_q       <= '0;
            cand_idx_q  <= '0;
            cand_val_q  <= '0;
            ptr_q       <= '0;
            min_index_q <= '0;
            min_value_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            num_q       <= num_d;
            cand_idx_q  <= cand_idx_d;
            cand_val_q  <= cand_val_d;
            ptr_q       <= ptr_d;
            min_index_q <= min_index_d;
            min_value_q <= min_value_d;
            valid_q     <= valid_d;
        end
    end

    assign num_flat     = num_q;
    assign min_index    = min_index_q;
    assign min_value    = min_value_q;
    assign result_valid = valid_q;
    assign char_min     = 8'h30 + {6'd0, min_index_q};

endmodule

// File: tb/tb_min_scan_controller.sv
// Randomized and directed bench for min_scan_controller against a cycle-count reference model.
// Inputs change on the falling edge; the model steps on the rising edge.
`timescale 1ns/1ps
module tb_min_scan_controller;

    localparam int W = 4;
    localparam int S = 2;

    logic           clk;
    logic           rst_n;
    logic [3:0]     pb;
    logic [W-1:0]   holder;
    logic           start;
    logic [4*W-1:0] num_flat;
    logic [1:0]     min_index;
    logic [W-1:0]   min_value;
    logic           result_valid;
    logic           done;
    logic           busy;
    logic [7:0]     char_min;

    min_scan_controller #(.W(W), .SYNC_STAGES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pb           (pb),
        .holder       (holder),
        .start        (start),
        .num_flat     (num_flat),
        .min_index    (min_index),
        .min_value    (min_value),
        .result_valid (result_valid),
        .done         (done),
        .busy         (busy),
        .char_min     (char_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int dut_done_cnt;

    // Reference model: raw button history, operands, and a countdown to the done cycle.
    logic [3:0]   hist [0:S];
    logic [W-1:0] m_ops  [4];
    logic [W-1:0] m_snap [4];
    int           m_pend;
    logic [1:0]   m_idx;
    logic [W-1:0] m_val;
    logic         m_valid;

    task automatic model_reset();
        for (int j = 0; j <= S; j++) hist[j] = 4'h0;
        for (int k = 0; k < 4; k++) begin
            m_ops[k]  = '0;
            m_snap[k] = '0;
        end
        m_pend  = -1;
        m_idx   = 2'd0;
        m_val   = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] m;
        bit was_done;
        m = hist[S-1] & ~hist[S];
        for (int j = S; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = pb;
        was_done = (m_pend == 0);
        if (was_done) begin
            m_val = m_snap[0];
            for (int k = 1; k < 4; k++) if (m_snap[k] < m_val) m_val = m_snap[k];
            for (int k = 3; k >= 0; k--) if (m_snap[k] == m_val) m_idx = 2'(k);
            if (m == 4'h0) m_valid = 1'b1;
        end
        for (int k = 0; k < 4; k++) if (m[k]) m_ops[k] = holder;
        if (m != 4'h0) m_valid = 1'b0;
        if (m != 4'h0 || (start && m_pend < 0)) begin
            m_pend = 4;
            for (int k = 0; k < 4; k++) m_snap[k] = m_ops[k];
        end else if (m_pend > 0) begin
            m_pend--;
        end else if (was_done) begin
            m_pend = -1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        if (done) dut_done_cnt++;
    endtask

    task automatic press(input logic [3:0] mask, input logic [W-1:0] val);
        holder = val;
        pb = pb | mask;
        repeat (S + 1) cycle();
        pb = pb & ~mask;
    endtask

    task automatic wait_done(input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            cycle();
            if (done) seen = 1'b1;
        end
    endtask

    task automatic load4(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d, output bit ok);
        bit seen;
        logic [W-1:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            press(4'(1 << k), v[k]);
            wait_done(20, seen);
            if (!seen) ok = 1'b0;
        end
        cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (num_flat !== '0)       begin n_fail++; $display("[TB] FAIL reset_num: got %h expected 0", num_flat); end
        n_checks++; if (min_index !== 2'd0)    begin n_fail++; $display("[TB] FAIL reset_min_index: got %0d expected 0", min_index); end
        n_checks++; if (min_value !== '0)      begin n_fail++; $display("[TB] FAIL reset_min_value: got %0d expected 0", min_value); end
        n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", result_valid); end
        n_checks++; if (done !== 1'b0)         begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (char_min !== 8'h30)    begin n_fail++; $display("[TB] FAIL reset_char: got %h expected 30", char_min); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic test_sequence_load();
        bit ok;
        load4(4'd9, 4'd4, 4'd7, 4'd2, ok);
        n_checks++; if (!ok)                   begin n_fail++; $display("[TB] FAIL seq_done_timeout: got timeout expected done"); end
        n_checks++; if (min_index !== 2'd3)    begin n_fail++; $display("[TB] FAIL seq_min_index: got %0d expected 3", min_index); end
        n_checks++; if (min_value !== 4'd2)    begin n_fail++; $display("[TB] FAIL seq_min_value: got %0d expected 2", min_value); end
        n_checks++; if (char_min !== 8'h33)    begin n_fail++; $display("[TB] FAIL seq_char: got %h expected 33", char_min); end
        n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL seq_valid: got %b expected 1", result_valid); end
    endtask

    task automatic test_tie_latency();
        bit ok;
        bit seen;
        int lat;
        load4(4'd5, 4'd3, 4'd3, 4'd8, ok);
        n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL tie_load_timeout: got timeout expected done"); end
        start = 1'b1;
        cycle();
        start = 1'b0;
        lat = 1;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            if (done) seen = 1'b1;
            else begin
                cycle();
                lat++;
            end
        end
        n_checks++; if (lat + 1 !== 6)      begin n_fail++; $display("[TB] FAIL tie_latency: got %0d expected 6", lat + 1); end
        cycle();
        n_checks++; if (min_index !== 2'd1) begin n_fail++; $display("[TB] FAIL tie_min_index: got %0d expected 1", min_index); end
        n_checks++; if (min_value !== 4'd3) begin n_fail++; $display("[TB] FAIL tie_min_value: got %0d expected 3", min_value); end
    endtask

    task automatic test_restart();
        bit ok;
        int d0;
        load4(4'd1, 4'd6, 4'd6, 4'd6, ok);
        n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL restart_load_timeout: got timeout expected done"); end
        d0 = dut_done_cnt;
        start = 1'b1;
        cycle();
        start = 1'b0;
        holder = 4'd0;
        pb[2] = 1'b1;
        repeat (3) cycle();
        pb[2] = 1'b0;
        repeat (15) cycle();
        n_checks++; if (dut_done_cnt - d0 !== 1) begin n_fail++; $display("[TB] FAIL restart_done_count: got %0d expected 1", dut_done_cnt - d0); end
        n_checks++; if (min_index !== 2'd2)      begin n_fail++; $display("[TB] FAIL restart_min_index: got %0d expected 2", min_index); end
        n_checks++; if (min_value !== 4'd0)      begin n_fail++; $display("[TB] FAIL restart_min_value: got %0d expected 0", min_value); end
        n_checks++; if (result_valid !== 1'b1)   begin n_fail++; $display("[TB] FAIL restart_valid: got %b expected 1", result_valid); end
    endtask

    task automatic test_simultaneous();
        bit seen;
        press(4'hF, 4'd8);
        wait_done(20, seen);
        cycle();
        press(4'b1010, 4'hF);
        wait_done(20, seen);
        n_checks++; if (!seen)                 begin n_fail++; $display("[TB] FAIL simul_timeout: got timeout expected done"); end
        cycle();
        n_checks++; if (num_flat !== 16'hF8F8) begin n_fail++; $display("[TB] FAIL simul_num: got %h expected F8F8", num_flat); end
        n_checks++; if (min_index !== 2'd0)    begin n_fail++; $display("[TB] FAIL simul_min_index: got %0d expected 0", min_index); end
        n_checks++; if (min_value !== 4'd8)    begin n_fail++; $display("[TB] FAIL simul_min_value: got %0d expected 8", min_value); end
    endtask

    task automatic test_hold();
        int d0;
        logic [W-1:0] h;
        h = 4'($urandom_range(0, 7));
        d0 = dut_done_cnt;
        holder = h;
        pb[2] = 1'b1;
        repeat (50) cycle();
        pb[2] = 1'b0;
        repeat (10) cycle();
        n_checks++; if (dut_done_cnt - d0 !== 1) begin n_fail++; $display("[TB] FAIL hold_done_count: got %0d expected 1", dut_done_cnt - d0); end
        n_checks++; if (num_flat[11:8] !== h)    begin n_fail++; $display("[TB] FAIL hold_num2: got %0d expected %0d", num_flat[11:8], h); end
        n_checks++; if (min_index !== 2'd2)      begin n_fail++; $display("[TB] FAIL hold_min_index: got %0d expected 2", min_index); end
        n_checks++; if (min_value !== h)         begin n_fail++; $display("[TB] FAIL hold_min_value: got %0d expected %0d", min_value, h); end
    endtask

    task automatic test_reset_mid_scan();
        int d0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (2) cycle();
        n_checks++; if (busy !== 1'b1)         begin n_fail++; $display("[TB] FAIL midreset_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_valid: got %b expected 0", result_valid); end
        n_checks++; if (num_flat !== '0)       begin n_fail++; $display("[TB] FAIL midreset_num: got %h expected 0", num_flat); end
        n_checks++; if (min_value !== '0)      begin n_fail++; $display("[TB] FAIL midreset_min_value: got %0d expected 0", min_value); end
        n_checks++; if (char_min !== 8'h30)    begin n_fail++; $display("[TB] FAIL midreset_char: got %h expected 30", char_min); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d0 = dut_done_cnt;
        repeat (20) cycle();
        n_checks++; if (dut_done_cnt !== d0)   begin n_fail++; $display("[TB] FAIL midreset_no_done: got %0d expected 0", dut_done_cnt - d0); end
        n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_valid_after: got %b expected 0", result_valid); end
    endtask

    task automatic test_held_at_reset();
        int d0;
        logic [W-1:0] v;
        v = 4'($urandom_range(1, 15));
        rst_n = 1'b0;
        model_reset();
        holder = v;
        pb = 4'b0010;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        d0 = dut_done_cnt;
        repeat (20) cycle();
        pb = 4'h0;
        repeat (5) cycle();
        n_checks++; if (num_flat[7:4] !== v)     begin n_fail++; $display("[TB] FAIL heldreset_num1: got %0d expected %0d", num_flat[7:4], v); end
        n_checks++; if (dut_done_cnt - d0 !== 1) begin n_fail++; $display("[TB] FAIL heldreset_done_count: got %0d expected 1", dut_done_cnt - d0); end
    endtask

    task automatic test_random();
        logic [4*W-1:0] exp_num;
        for (int i = 0; i < 400; i++) begin
            pb     = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'h0;
            start  = ($urandom_range(0, 5) == 0);
            holder = 4'($urandom);
            cycle();
            exp_num = {m_ops[3], m_ops[2], m_ops[1], m_ops[0]};
            n_checks++; if (done !== (m_pend == 0))     begin n_fail++; $display("[TB] FAIL rand_done @%0d: got %b expected %b", i, done, m_pend == 0); end
            n_checks++; if (busy !== (m_pend > 0))      begin n_fail++; $display("[TB] FAIL rand_busy @%0d: got %b expected %b", i, busy, m_pend > 0); end
            n_checks++; if (result_valid !== m_valid)   begin n_fail++; $display("[TB] FAIL rand_valid @%0d: got %b expected %b", i, result_valid, m_valid); end
            n_checks++; if (min_index !== m_idx)        begin n_fail++; $display("[TB] FAIL rand_min_index @%0d: got %0d expected %0d", i, min_index, m_idx); end
            n_checks++; if (min_value !== m_val)        begin n_fail++; $display("[TB] FAIL rand_min_value @%0d: got %0d expected %0d", i, min_value, m_val); end
            n_checks++; if (num_flat !== exp_num)       begin n_fail++; $display("[TB] FAIL rand_num @%0d: got %h expected %h", i, num_flat, exp_num); end
            n_checks++; if (char_min !== 8'h30 + m_idx) begin n_fail++; $display("[TB] FAIL rand_char @%0d: got %h expected %h", i, char_min, 8'h30 + m_idx); end
        end
        pb = 4'h0;
        start = 1'b0;
        repeat (10) cycle();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        dut_done_cnt = 0;
        pb           = 4'h0;
        holder       = '0;
        start        = 1'b0;
        model_reset();
        test_reset();
        test_sequence_load();
        test_tie_latency();
        test_restart();
        test_simultaneous();
        test_hold();
        test_reset_mid_scan();
        test_held_at_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
